control_loop_dac_out: RTL and testbench
=======================================

// Module: control_loop_dac_out
// PURPOSE
//  Downstream stage of the control-loop math block: takes its OUT_WHOLE.OUT_FRAC adjustment value,
//  rounds it to integer ADC counts, scales by the runtime ADC->DAC ratio, saturates to a DAC code,
//  and issues one write word to the DAC SPI master. It handshakes with the math block (finished/arm)
//  on one side and the SPI master (arm/finished) on the other.
// PARAMETERS
//  OUT_WHOLE    20       whole bits of adj_val (signed, two's complement)
//  OUT_FRAC     40       fractional bits of adj_val
//  DAC_DATA_WID 20       DAC code width (signed)
//  SCALE_WID    24       width of unsigned scale input
//  SCALE_FRAC   20       fractional bits of scale (1.0 = 1<<SCALE_FRAC)
//  DAC_CMD      4'b0001  command nibble placed above dac_code in spi_word
// PORTS
//  clk          in   1                      system clock
//  rst_L        in   1                      asynchronous active-low reset
//  adj_val      in   OUT_WHOLE+OUT_FRAC     adjustment value from control_loop_math
//  adj_valid    in   1                      math block finished (level)
//  adj_ack      out  1                      value consumed; held until adj_valid falls
//  scale        in   SCALE_WID              ADC-LSB -> DAC-LSB ratio, unsigned fixed point
//  spi_arm      out  1                      arm the DAC SPI master
//  spi_finished in   1                      SPI master transfer complete (level)
//  spi_word     out  DAC_DATA_WID+4         {DAC_CMD, dac_code}, stable while spi_arm=1
//  dac_code     out  DAC_DATA_WID           last code written (signed)
//  saturated    out  1                      last code was clipped
//  busy         out  1                      high in every state except IDLE
// BEHAVIOUR
//  Reset (rst_L=0, any time, incl. mid-transaction): state=IDLE; adj_ack, spi_arm, saturated, busy=0;
//   dac_code=0; spi_word={DAC_CMD,0}; multiplier registers cleared. No SPI arm is left pending.
//  States: IDLE -> LATCH -> MULT -> SAT -> SEND -> RELEASE -> ACK -> IDLE.
//  IDLE: on adj_valid=1, register adj_val; go to LATCH.
//  LATCH (1 cycle): r = adj_val[W-1:OUT_FRAC] + adj_val[OUT_FRAC-1], sign-extended to
//   OUT_WHOLE+1 bits (round half toward +inf, no overflow); scale latched; go to MULT.
//  MULT: sequential shift-add of signed r by unsigned scale, one scale bit per cycle, LSB first,
//   exactly SCALE_WID cycles; product width OUT_WHOLE+SCALE_WID+1, signed; then SAT.
//  SAT (1 cycle): arithmetic-shift product right SCALE_FRAC (truncate toward -inf); clamp to
//   [-2^(DAC_DATA_WID-1), 2^(DAC_DATA_WID-1)-1]; load dac_code and spi_word; saturated=1 iff clamped.
//  Latency: spi_arm rises SCALE_WID+3 cycles after the IDLE cycle that sees adj_valid=1.
//  SEND: spi_arm=1 until spi_finished=1 sampled; then spi_arm=0 next cycle, go to RELEASE.
//  RELEASE: wait spi_finished=0 (SPI master disarm handshake); go to ACK.
//  ACK: adj_ack=1 while adj_valid=1; when adj_valid=0, adj_ack=0 next cycle, go to IDLE.
//  adj_valid falling before ACK is ignored; the transaction completes and ACK exits immediately.
//  adj_val/scale changes after LATCH do not affect the transaction in flight.
//  spi_finished=1 already in IDLE/MULT is ignored; only sampled in SEND/RELEASE.
//  scale=0 -> dac_code=0, saturated=0. dac_code/saturated hold between transactions.
//  One transaction in flight; a new adj_valid is accepted only in IDLE.
// TESTING
//  scale=1<<20, adj_val=5.5 (0x5<<40 | 1<<39) -> dac_code=6, saturated=0, spi_word=0x100006, arm at +27.
//  scale=1<<20, adj_val=-5.5 -> r=-5, dac_code=0xFFFFB, saturated=0.
//  scale=4.096 (0x418937), adj_val=0x7FFFF.0 -> dac_code=0x7FFFF, saturated=1; adj_val=-2^19 -> 0x80000, saturated=1.
//  SPI master holds spi_finished low 100 cycles then high 3 cycles -> spi_arm high exactly until
//   first spi_finished sample; adj_ack rises only after spi_finished falls; one SPI word total.
//  rst_L low in MULT cycle 10 -> all outputs at reset values immediately; after release, adj_valid=1
//   with adj_val=1.0, scale=1<<20 -> clean transaction, dac_code=1.
//  adj_valid dropped during MULT -> SPI write still issued, adj_ack pulses 1 cycle, back to IDLE, busy=0.

Source files
------------

// File: rtl/control_loop_dac_out_if.sv
// Handshake and data bundle between the control-loop math block, this DAC
// output stage and the DAC SPI master.
interface control_loop_dac_out_if #(
  parameter int OUT_WHOLE    = 20,
  parameter int OUT_FRAC     = 40,
  parameter int DAC_DATA_WID = 20,
  parameter int SCALE_WID    = 24
);
  logic [OUT_WHOLE+OUT_FRAC-1:0] adj_val;
  logic                          adj_valid;
  logic                          adj_ack;
  logic [SCALE_WID-1:0]          scale;
  logic                          spi_arm;
  logic                          spi_finished;
  logic [DAC_DATA_WID+3:0]       spi_word;
  logic [DAC_DATA_WID-1:0]       dac_code;
  logic                          saturated;
  logic                          busy;

  // Side that feeds the stage: math block plus SPI master
  modport master (
    output adj_val, adj_valid, scale, spi_finished,
    input  adj_ack, spi_arm, spi_word, dac_code, saturated, busy
  );

  // The DAC output stage itself
  modport slave (
    input  adj_val, adj_valid, scale, spi_finished,
    output adj_ack, spi_arm, spi_word, dac_code, saturated, busy
  );
endinterface

// File: rtl/control_loop_dac_out.sv
// DAC output stage: rounds the math block's fixed-point adjustment to whole
// ADC counts, scales it by the ADC->DAC ratio with a bit-serial multiplier,
// clamps to the DAC code range and hands one word to the SPI master.
module control_loop_dac_out #(
  parameter int         OUT_WHOLE    = 20,
  parameter int         OUT_FRAC     = 40,
  parameter int         DAC_DATA_WID = 20,
  parameter int         SCALE_WID    = 24,
  parameter int         SCALE_FRAC   = 20,
  parameter logic [3:0] DAC_CMD      = 4'b0001
) (
  input  logic                  clk,
  input  logic                  rst_L,
  control_loop_dac_out_if.slave bus
);
  localparam int R_WID    = OUT_WHOLE + 1;
  localparam int PROD_WID = OUT_WHOLE + SCALE_WID + 1;
  localparam int CNT_WID  = $clog2(SCALE_WID);
  localparam logic [CNT_WID-1:0] CNT_LAST = CNT_WID'(SCALE_WID - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_MULT, S_SAT, S_SEND, S_RELEASE, S_ACK
  } state_t;

  state_t                    r_state;
  state_t                    w_state_next;
  logic [OUT_WHOLE-1:0]      r_adj_whole;
  logic                      r_adj_half;
  logic signed [PROD_WID-1:0] r_mcand;
  logic signed [PROD_WID-1:0] r_prod;
  logic [SCALE_WID-1:0]      r_mplier;
  logic [CNT_WID-1:0]        r_cnt;
  logic [DAC_DATA_WID-1:0]   r_dac_code;
  logic [DAC_DATA_WID+3:0]   r_spi_word;
  logic                      r_saturated;
  logic                      r_spi_arm;
  logic                      r_adj_ack;
  logic                      r_busy;

  logic [R_WID-1:0]          w_round;
  logic signed [PROD_WID-1:0] w_shifted;
  logic                      w_fits;
  logic [DAC_DATA_WID-1:0]   w_clamped;
  logic                      w_unused;

  // Only the whole part and the half bit matter for rounding
  assign w_unused = ^bus.adj_val[OUT_FRAC-2:0];

  // Round half toward +inf; one extra bit keeps +max whole plus a half exact
  assign w_round = {r_adj_whole[OUT_WHOLE-1], r_adj_whole} + R_WID'(r_adj_half);

  // Drop the scale's fractional bits (floor), then clamp to the DAC range
  assign w_shifted = r_prod >>> SCALE_FRAC;
  assign w_fits    = (&w_shifted[PROD_WID-1:DAC_DATA_WID-1]) |
                     ~(|w_shifted[PROD_WID-1:DAC_DATA_WID-1]);
  assign w_clamped = w_fits ? w_shifted[DAC_DATA_WID-1:0] :
                     (w_shifted[PROD_WID-1] ? {1'b1, {(DAC_DATA_WID-1){1'b0}}}
                                            : {1'b0, {(DAC_DATA_WID-1){1'b1}}});

  // State register
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic: one transaction at a time, both handshakes fully closed
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (bus.adj_valid)     w_state_next = S_LATCH;
      S_LATCH:                          w_state_next = S_MULT;
      S_MULT:    if (r_cnt == CNT_LAST) w_state_next = S_SAT;
      S_SAT:                            w_state_next = S_SEND;
      S_SEND:    if (bus.spi_finished)  w_state_next = S_RELEASE;
      S_RELEASE: if (!bus.spi_finished) w_state_next = S_ACK;
      S_ACK:     if (!bus.adj_valid)    w_state_next = S_IDLE;
      default:                          w_state_next = S_IDLE;
    endcase
  end

  // Handshake outputs registered from the next state so they are glitch-free
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      r_spi_arm <= 1'b0;
      r_adj_ack <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_spi_arm <= (w_state_next == S_SEND);
      r_adj_ack <= (w_state_next == S_ACK);
      r_busy    <= (w_state_next != S_IDLE);
    end
  end

  // Datapath: capture, round, shift-add multiply, clamp
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      r_adj_whole <= '0;
      r_adj_half  <= 1'b0;
      r_mcand     <= '0;
      r_prod      <= '0;
      r_mplier    <= '0;
      r_cnt       <= '0;
      r_dac_code  <= '0;
      r_saturated <= 1'b0;
      r_spi_word  <= {DAC_CMD, {DAC_DATA_WID{1'b0}}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.adj_valid) begin
            r_adj_whole <= bus.adj_val[OUT_WHOLE+OUT_FRAC-1:OUT_FRAC];
            r_adj_half  <= bus.adj_val[OUT_FRAC-1];
          end
        end
        S_LATCH: begin
          r_mcand  <= {{(PROD_WID-R_WID){w_round[R_WID-1]}}, w_round};
          r_mplier <= bus.scale;
          r_prod   <= '0;
          r_cnt    <= '0;
        end
        S_MULT: begin
          if (r_mplier[0]) r_prod <= r_prod + r_mcand;
          r_mcand  <= r_mcand <<< 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
        end
        S_SAT: begin
          r_dac_code  <= w_clamped;
          r_saturated <= ~w_fits;
          r_spi_word  <= {DAC_CMD, w_clamped};
        end
        default: ;
      endcase
    end
  end

  assign bus.adj_ack   = r_adj_ack;
  assign bus.spi_arm   = r_spi_arm;
  assign bus.spi_word  = r_spi_word;
  assign bus.dac_code  = r_dac_code;
  assign bus.saturated = r_saturated;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_control_loop_dac_out.sv
// Directed bench for control_loop_dac_out: each task drives one scenario and
// checks hand-computed results inline.
module tb_control_loop_dac_out;
  logic clk;
  logic rst_L;
  int   errors = 0;
  int   checks = 0;

  control_loop_dac_out_if bus ();

  control_loop_dac_out dut (
    .clk   (clk),
    .rst_L (rst_L),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observations gathered by run_txn
  int          t_lat;
  int          t_arm;
  int          t_words;
  int          t_ack_cnt;
  bit          t_ack_early;
  bit          t_timeout;
  logic [23:0] t_word;

  // Drives one transaction and plays the SPI master; records what it saw.
  task automatic run_txn(input logic [59:0] a, input logic [23:0] s,
                         input int delay, input int hold, input bit drop_early);
    bit prev_arm;
    bus.adj_val = a;
    bus.scale = s;
    bus.adj_valid = 1'b1;
    bus.spi_finished = 1'b0;
    t_lat = 0; t_arm = 0; t_words = 0; t_ack_cnt = 0;
    t_ack_early = 0; t_timeout = 0; t_word = '0;
    prev_arm = 1'b0;
    while (!bus.spi_arm && t_lat < 200) begin
      @(negedge clk);
      t_lat++;
      if (drop_early && t_lat == 10) begin
        bus.adj_valid = 1'b0;
        bus.adj_val = 60'hABCDE_12345_6789A;
        bus.scale = 24'hFFFFFF;
      end
    end
    if (!bus.spi_arm) begin
      t_timeout = 1;
      return;
    end
    for (int i = 0; i <= delay + hold + 5; i++) begin
      if (i > 0) @(negedge clk);
      if (bus.spi_arm) t_arm++;
      if (bus.spi_arm && !prev_arm) t_words++;
      prev_arm = bus.spi_arm;
      if (i == 0) t_word = bus.spi_word;
      if (bus.adj_ack && i <= delay + hold) t_ack_early = 1;
      if (bus.adj_ack) t_ack_cnt++;
      bus.spi_finished = (i >= delay && i < delay + hold);
    end
  endtask

  // Closes a normal transaction by dropping adj_valid and checks return to IDLE
  task automatic finish_txn(input string name);
    bus.adj_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.adj_ack !== 1'b0) begin
      errors++;
      $display("FAIL %s ack_release: got %b want 0", name, bus.adj_ack);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_idle: got %b want 0", name, bus.busy);
    end
  endtask

  task automatic test_reset;
    rst_L = 1'b0;
    bus.adj_valid = 1'b0;
    bus.adj_val = '0;
    bus.scale = '0;
    bus.spi_finished = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.adj_ack, bus.spi_arm, bus.saturated, bus.busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0000",
               {bus.adj_ack, bus.spi_arm, bus.saturated, bus.busy});
    end
    checks++;
    if (bus.dac_code !== 20'h0) begin
      errors++;
      $display("FAIL reset_code: got %h want 00000", bus.dac_code);
    end
    checks++;
    if (bus.spi_word !== 24'h100000) begin
      errors++;
      $display("FAIL reset_word: got %h want 100000", bus.spi_word);
    end
    rst_L = 1'b1;
    @(negedge clk);
    $display("test_reset done");
  endtask

  // One normal transaction with fast SPI, checks code, flags, word and timing
  task automatic test_code(input string name, input logic [59:0] a,
                           input logic [23:0] s, input logic [19:0] exp_code,
                           input logic exp_sat);
    run_txn(a, s, 0, 1, 1'b0);
    checks++;
    if (t_timeout) begin
      errors++;
      $display("FAIL %s timeout: spi_arm never rose", name);
      bus.adj_valid = 1'b0;
      return;
    end
    checks++;
    if (t_lat !== 27) begin
      errors++;
      $display("FAIL %s latency: got %0d want 27", name, t_lat);
    end
    checks++;
    if (bus.dac_code !== exp_code) begin
      errors++;
      $display("FAIL %s dac_code: got %h want %h", name, bus.dac_code, exp_code);
    end
    checks++;
    if (bus.saturated !== exp_sat) begin
      errors++;
      $display("FAIL %s saturated: got %b want %b", name, bus.saturated, exp_sat);
    end
    checks++;
    if (t_word !== {4'b0001, exp_code}) begin
      errors++;
      $display("FAIL %s spi_word: got %h want %h", name, t_word, {4'b0001, exp_code});
    end
    checks++;
    if (t_arm !== 1 || t_words !== 1) begin
      errors++;
      $display("FAIL %s arm: got cycles=%0d words=%0d want 1/1", name, t_arm, t_words);
    end
    checks++;
    if (t_ack_early || t_ack_cnt !== 5) begin
      errors++;
      $display("FAIL %s ack: got early=%0d cnt=%0d want 0/5", name, t_ack_early, t_ack_cnt);
    end
    finish_txn(name);
    $display("%s: code=%h sat=%b lat=%0d", name, bus.dac_code, bus.saturated, t_lat);
  endtask

  task automatic test_reset_mid_mult;
    bus.adj_val = 60'h5 << 40;
    bus.scale = 24'h100000;
    bus.adj_valid = 1'b1;
    repeat (11) @(negedge clk);
    #2 rst_L = 1'b0;
    #1;
    checks++;
    if ({bus.adj_ack, bus.spi_arm, bus.saturated, bus.busy} !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_flags: got %b want 0000",
               {bus.adj_ack, bus.spi_arm, bus.saturated, bus.busy});
    end
    checks++;
    if (bus.dac_code !== 20'h0 || bus.spi_word !== 24'h100000) begin
      errors++;
      $display("FAIL midreset_code: got %h/%h want 00000/100000", bus.dac_code, bus.spi_word);
    end
    bus.adj_valid = 1'b0;
    @(negedge clk);
    rst_L = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.spi_arm !== 1'b0) begin
      errors++;
      $display("FAIL midreset_after: got busy=%b arm=%b want 0/0", bus.busy, bus.spi_arm);
    end
    $display("test_reset_mid_mult done");
    test_code("after_reset", 60'h1 << 40, 24'h100000, 20'h00001, 1'b0);
  endtask

  task automatic test_valid_drop;
    run_txn((60'h5 << 40) | (60'h1 << 39), 24'h100000, 0, 1, 1'b1);
    checks++;
    if (t_timeout) begin
      errors++;
      $display("FAIL drop timeout: spi_arm never rose");
      return;
    end
    checks++;
    if (bus.dac_code !== 20'h00006 || t_words !== 1) begin
      errors++;
      $display("FAIL drop_write: got code=%h words=%0d want 00006/1", bus.dac_code, t_words);
    end
    checks++;
    if (t_ack_cnt !== 1 || t_ack_early) begin
      errors++;
      $display("FAIL drop_ack: got cnt=%0d early=%0d want 1/0", t_ack_cnt, t_ack_early);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_busy: got %b want 0", bus.busy);
    end
    $display("test_valid_drop: code=%h ack_cycles=%0d", bus.dac_code, t_ack_cnt);
  endtask

  task automatic test_slow_spi;
    run_txn(-((60'h5 << 40) | (60'h1 << 39)), 24'h100000, 100, 3, 1'b0);
    checks++;
    if (t_timeout) begin
      errors++;
      $display("FAIL slow timeout: spi_arm never rose");
      bus.adj_valid = 1'b0;
      return;
    end
    checks++;
    if (t_arm !== 101 || t_words !== 1) begin
      errors++;
      $display("FAIL slow_arm: got cycles=%0d words=%0d want 101/1", t_arm, t_words);
    end
    checks++;
    if (t_ack_early || t_ack_cnt !== 5) begin
      errors++;
      $display("FAIL slow_ack: got early=%0d cnt=%0d want 0/5", t_ack_early, t_ack_cnt);
    end
    checks++;
    if (bus.dac_code !== 20'hFFFFB) begin
      errors++;
      $display("FAIL slow_code: got %h want FFFFB", bus.dac_code);
    end
    finish_txn("slow");
    $display("test_slow_spi: arm_cycles=%0d code=%h", t_arm, bus.dac_code);
  endtask

  initial begin
    test_reset();
    test_code("pos_5p5", (60'h5 << 40) | (60'h1 << 39), 24'h100000, 20'h00006, 1'b0);
    test_code("neg_5p5", -((60'h5 << 40) | (60'h1 << 39)), 24'h100000, 20'hFFFFB, 1'b0);
    test_code("sat_pos", 60'h7FFFF << 40, 24'h418937, 20'h7FFFF, 1'b1);
    test_code("sat_neg", 60'h80000 << 40, 24'h418937, 20'h80000, 1'b1);
    test_reset_mid_mult();
    test_code("scale_zero", (60'h5 << 40) | (60'h1 << 39), 24'h000000, 20'h00000, 1'b0);
    test_valid_drop();
    test_slow_spi();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
